// File: rtl/factor_mult_pkg.sv
// Shared definitions for the factor_mult multiplicity stage: FSM states,
// default operand width and the exponent-width rule.
package factor_mult_pkg;

    localparam int W_DEF = 8;

    // Holds multiplicities up to W-1.
    function automatic int exp_width(input int w);
        return $clog2(w) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DIV   = 2'd2
    } state_t;

endpackage

// File: rtl/factor_mult_div.sv
// One repeated-subtraction division pass: load a dividend, then subtract the
// divisor once per step until the remainder drops below it.
module factor_mult_div
    import factor_mult_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    input  logic [W-1:0] dr,
    output logic [W-1:0] quot,
    output logic         ge,
    output logic         rem_zero
);

    logic [W-1:0] rem;

    assign ge       = (rem >= dr);
    assign rem_zero = (rem == '0);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rem  <= '0;
            quot <= '0;
        end else if (load) begin
            rem  <= load_val;
            quot <= '0;
        end else if (step && ge) begin
            rem  <= rem - dr;
            quot <= quot + W'(1);
        end
    end

endmodule

// File: rtl/factor_mult.sv
// Strips every factor D out of A, reporting multiplicity E and cofactor Q.
// Work starts on a rising edge of valid; done pulses once per request.
//
// state | meaning
// IDLE  | waiting for a rising edge on valid; results held
// CHECK | shortcut cases (A<2, invalid D, D==A) or load first divide pass
// DIV   | one subtraction per cycle; each exact pass bumps E and re-divides
module factor_mult
    import factor_mult_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int EW = exp_width(W)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  D,
    input  logic          valid,
    output logic          busy,
    output logic [W-1:0]  P,
    output logic [EW-1:0] E,
    output logic [W-1:0]  Q,
    output logic          err,
    output logic          done
);

    localparam logic [W-1:0]  ONE_W  = W'(1);
    localparam logic [W-1:0]  TWO_W  = W'(2);
    localparam logic [EW-1:0] ONE_EW = EW'(1);

    state_t        state, state_nxt;
    logic          valid_q;
    logic [W-1:0]  n_r, n_nxt;
    logic [W-1:0]  dr_r, dr_nxt;
    logic [W-1:0]  p_nxt, q_nxt;
    logic [EW-1:0] e_nxt;
    logic          err_nxt, busy_nxt, finish;

    logic          sd_load, sd_step, sd_ge, sd_zero;
    logic [W-1:0]  sd_load_val, sd_quot;

    logic accept;
    assign accept = valid && !valid_q;

    factor_mult_div #(.W(W)) u_div (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (sd_load),
        .load_val (sd_load_val),
        .step     (sd_step),
        .dr       (dr_r),
        .quot     (sd_quot),
        .ge       (sd_ge),
        .rem_zero (sd_zero)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            n_r     <= '0;
            dr_r    <= '0;
            busy    <= 1'b0;
            P       <= '0;
            E       <= '0;
            Q       <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid_q <= valid;
            n_r     <= n_nxt;
            dr_r    <= dr_nxt;
            busy    <= busy_nxt;
            P       <= p_nxt;
            E       <= e_nxt;
            Q       <= q_nxt;
            err     <= err_nxt;
            done    <= finish;
        end
    end

    always_comb begin
        state_nxt   = state;
        n_nxt       = n_r;
        dr_nxt      = dr_r;
        p_nxt       = P;
        e_nxt       = E;
        q_nxt       = Q;
        err_nxt     = err;
        busy_nxt    = busy;
        finish      = 1'b0;
        sd_load     = 1'b0;
        sd_step     = 1'b0;
        sd_load_val = sd_quot;

        case (state)
            IDLE: begin
                if (accept) begin
                    n_nxt     = A;
                    dr_nxt    = D;
                    err_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                sd_load_val = n_r;
                if (n_r < TWO_W) begin
                    p_nxt  = n_r;
                    e_nxt  = '0;
                    q_nxt  = n_r;
                    finish = 1'b1;
                end else if ((dr_r < TWO_W) || (dr_r > n_r)) begin
                    err_nxt = 1'b1;
                    p_nxt   = dr_r;
                    e_nxt   = '0;
                    q_nxt   = n_r;
                    finish  = 1'b1;
                end else if (dr_r == n_r) begin
                    p_nxt  = dr_r;
                    e_nxt  = ONE_EW;
                    q_nxt  = ONE_W;
                    finish = 1'b1;
                end else begin
                    sd_load   = 1'b1;
                    e_nxt     = '0;
                    p_nxt     = dr_r;
                    state_nxt = DIV;
                end
            end
            DIV: begin
                if (sd_ge) begin
                    sd_step = 1'b1;
                end else if (sd_zero) begin
                    // Exact division: the quotient becomes the new number.
                    n_nxt = sd_quot;
                    e_nxt = E + ONE_EW;
                    if (sd_quot >= dr_r) begin
                        sd_load = 1'b1;
                    end else begin
                        q_nxt  = sd_quot;
                        finish = 1'b1;
                    end
                end else begin
                    q_nxt  = n_r;
                    finish = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (finish) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
        end
    end

endmodule

// File: tb/tb_factor_mult.sv
// Directed bench for factor_mult: result values, done latency, valid edge
// handling and asynchronous reset abort.
module tb_factor_mult;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] A, D;
    logic       valid;
    logic       busy, err, done;
    logic [7:0] P, Q;
    logic [3:0] E;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    factor_mult dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .A     (A),
        .D     (D),
        .valid (valid),
        .busy  (busy),
        .P     (P),
        .E     (E),
        .Q     (Q),
        .err   (err),
        .done  (done)
    );

    // Stimulus only: raise valid, count edges from accept to done, note busy gaps.
    task automatic run_op(input logic [7:0] a, input logic [7:0] d, input bit hold,
                          output int cyc, output bit tmo, output bit busy_bad);
        @(negedge Clk);
        A = a; D = d; valid = 1'b1;
        @(posedge Clk); #1;
        busy_bad = (busy !== 1'b1);
        cyc = 0;
        tmo = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge Clk); #1;
            cyc++;
            if (done === 1'b1) begin
                tmo = 1'b0;
                if (busy !== 1'b0) busy_bad = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
        if (!hold) begin
            @(negedge Clk);
            valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; valid = 1'b0; A = '0; D = '0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({busy, P, E, Q, err, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b P=%0d E=%0d Q=%0d err=%0b done=%0b, want all 0",
                     busy, P, E, Q, err, done);
        end
        @(negedge Clk); Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%0b done=%0b, want 0 0", busy, done);
        end
    endtask

    task automatic test_twelve_by_two();
        int cyc; bit tmo, bb;
        run_op(8'd12, 8'd2, 1'b0, cyc, tmo, bb);
        checks++;
        if (tmo || cyc != 14) begin
            errors++;
            $display("FAIL a12_latency: got %0d edges (timeout=%0b), want 14", cyc, tmo);
        end
        checks++;
        if ({P, E, Q, err} !== {8'd2, 4'd2, 8'd3, 1'b0}) begin
            errors++;
            $display("FAIL a12_result: got P=%0d E=%0d Q=%0d err=%0b, want P=2 E=2 Q=3 err=0", P, E, Q, err);
        end
        checks++;
        if (bb) begin
            errors++;
            $display("FAIL a12_busy: got busy gap or busy with done, want busy high until done");
        end
        @(posedge Clk); #1;
        checks++;
        if (done !== 1'b0 || P !== 8'd2 || Q !== 8'd3) begin
            errors++;
            $display("FAIL a12_pulse_hold: got done=%0b P=%0d Q=%0d, want done=0 P=2 Q=3", done, P, Q);
        end
    endtask

    task automatic test_equal();
        int cyc; bit tmo, bb;
        run_op(8'd31, 8'd31, 1'b0, cyc, tmo, bb);
        checks++;
        if (tmo || cyc != 1 || {P, E, Q, err} !== {8'd31, 4'd1, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL a31_equal: got edges=%0d P=%0d E=%0d Q=%0d err=%0b, want 1 31 1 1 0",
                     cyc, P, E, Q, err);
        end
    endtask

    task automatic test_powers();
        int cyc; bit tmo, bb;
        // Re-raise valid mid-run: that edge must be ignored.
        fork
            run_op(8'd128, 8'd2, 1'b0, cyc, tmo, bb);
            begin
                repeat (20) @(negedge Clk);
                valid = 1'b0;
                @(negedge Clk);
                valid = 1'b1;
            end
        join
        checks++;
        if (tmo || {P, E, Q, err} !== {8'd2, 4'd7, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL a128: got P=%0d E=%0d Q=%0d err=%0b timeout=%0b, want P=2 E=7 Q=1 err=0",
                     P, E, Q, err, tmo);
        end
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_edge_dropped: got busy=%0b, want 0", busy);
        end
        run_op(8'd255, 8'd3, 1'b0, cyc, tmo, bb);
        checks++;
        if (tmo || cyc != 116 || {P, E, Q, err} !== {8'd3, 4'd1, 8'd85, 1'b0}) begin
            errors++;
            $display("FAIL a255: got edges=%0d P=%0d E=%0d Q=%0d err=%0b, want 116 3 1 85 0",
                     cyc, P, E, Q, err);
        end
    endtask

    task automatic test_shortcuts();
        int cyc; bit tmo, bb;
        run_op(8'd1, 8'd1, 1'b0, cyc, tmo, bb);
        checks++;
        if (tmo || cyc != 1 || {P, E, Q, err} !== {8'd1, 4'd0, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL a1: got edges=%0d P=%0d E=%0d Q=%0d err=%0b, want 1 1 0 1 0", cyc, P, E, Q, err);
        end
        run_op(8'd10, 8'd0, 1'b0, cyc, tmo, bb);
        checks++;
        if (tmo || cyc != 1 || {P, E, Q, err} !== {8'd0, 4'd0, 8'd10, 1'b1}) begin
            errors++;
            $display("FAIL d0: got edges=%0d P=%0d E=%0d Q=%0d err=%0b, want 1 0 0 10 1", cyc, P, E, Q, err);
        end
        run_op(8'd5, 8'd7, 1'b0, cyc, tmo, bb);
        checks++;
        if (tmo || {P, E, Q, err} !== {8'd7, 4'd0, 8'd5, 1'b1}) begin
            errors++;
            $display("FAIL d_gt_a: got P=%0d E=%0d Q=%0d err=%0b, want 7 0 5 1", P, E, Q, err);
        end
        run_op(8'd20, 8'd3, 1'b0, cyc, tmo, bb);
        checks++;
        if (tmo || cyc != 8 || {P, E, Q, err} !== {8'd3, 4'd0, 8'd20, 1'b0}) begin
            errors++;
            $display("FAIL a20_d3: got edges=%0d P=%0d E=%0d Q=%0d err=%0b, want 8 3 0 20 0",
                     cyc, P, E, Q, err);
        end
    endtask

    task automatic test_level_hold();
        int cyc; bit tmo, bb, seen;
        run_op(8'd12, 8'd2, 1'b1, cyc, tmo, bb);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL level_hold: got busy/done activity with valid held, want none");
        end
        @(negedge Clk); valid = 1'b0;
        run_op(8'd9, 8'd3, 1'b0, cyc, tmo, bb);
        checks++;
        if (tmo || {P, E, Q, err} !== {8'd3, 4'd2, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL a9_d3: got P=%0d E=%0d Q=%0d err=%0b, want 3 2 1 0", P, E, Q, err);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge Clk);
        A = 8'd200; D = 8'd2; valid = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got busy=%0b, want 1", busy);
        end
        #1;
        Rst = 1'b1; valid = 1'b0;
        #1;
        checks++;
        if ({busy, P, E, Q, err, done} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%0b P=%0d E=%0d Q=%0d err=%0b done=%0b, want all 0",
                     busy, P, E, Q, err, done);
        end
        @(negedge Clk); Rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL post_reset_quiet: got busy/done without a valid edge, want none");
        end
    endtask

    initial begin
        test_reset();
        test_twelve_by_two();
        test_equal();
        test_powers();
        test_shortcuts();
        test_level_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/factor_mult.md
# factor_mult

Downstream stage of the smallest-divisor engine. Takes a number A and its divisor D, sets P = D, and strips every factor D out of A by repeated subtraction. It reports the multiplicity E and the remaining cofactor Q. Chaining it with the divisor engine, with Q fed back as the next A, yields a full prime factorisation.

## Interface
- W, 8, operand width.
- EW, $clog2(W)+1, exponent width (4 for W=8). This holds the maximum multiplicity W-1.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- A  in  W  number to reduce; sampled on accept.
- D  in  W  divisor from the upstream stage; sampled on accept.
- valid  in  1  upstream result-ready level; a rising edge requests work.
- busy  out  1  high from the accept edge until the done edge.
- P  out  W  divisor echoed (D), or A when A<2.
- E  out  EW  multiplicity of P in A.
- Q  out  W  cofactor, A / P^E.
- err  out  1  D invalid (D<2 or D>A while A≥2).
- done  out  1  one-cycle pulse; results valid from this edge on.

## Operation
- Reset: state IDLE. busy, P, E, Q, err, done, the internal registers and valid_q are all 0.
- Accept happens in IDLE when valid=1 and valid_q=0 (rising edge; valid_q is valid delayed by one clock).
  - A level-held valid never re-triggers.
  - Edges that occur while busy are dropped, not queued.
- On accept:
  - latch N←A and Dr←D;
  - clear err;
  - busy←1;
  - go to CHECK.
- CHECK, first matching rule:
  - A<2: P←A, E←0, Q←A; finish.
  - D<2 or D>A: err←1, P←D, E←0, Q←A; finish.
  - D==A: P←D, E←1, Q←1; finish.
  - otherwise: rem←N, quot←0, E←0, P←D; go to DIV.
- DIV, one step per cycle:
  - rem≥Dr: rem←rem−Dr, quot←quot+1.
  - rem<Dr and rem==0: N←quot, E←E+1.
    - If quot≥Dr: rem←quot, quot←0; stay in DIV.
    - Else: Q←quot; finish.
  - rem<Dr and rem≠0: Q←N; finish.
- Finish happens on a single edge: done←1, busy←0, state←IDLE.
- P, E, Q and err hold until the next accept.
- All arithmetic is unsigned at width W; rem never underflows.
- E never exceeds W−1, so no saturation logic is needed.
- Rst asserted mid-operation aborts immediately; all outputs return to 0.

## Timing
- Accept edge: busy rises.
- Shortcut cases (A<2, err, D==A): done at accept+1 edge (CHECK).
- DIV path:
  - each pass with quotient q costs q+1 cycles;
  - done edge = accept + 1 + Σ(q_i+1).
  - Example: A=12, D=2 → passes q=6, 3, 1 → done 14 edges after accept.
- done is high for exactly one cycle; busy and done are never high together.
- valid_q updates every cycle regardless of state, so edge detection is state-independent.

## Structure
- Shared header prim_defs.vh holds:
  - state encodings IDLE, CHECK, DIV;
  - default W;
  - the EW expression.
- One natural sub-module, sub_div:
  - a single repeated-subtraction divider pass (rem/quot registers, load, step, zero-remainder flag);
  - instantiated once and reloaded per pass.
- Top level holds edge detect, the FSM, N/E/Q bookkeeping and output registers.
- Estimated size: roughly 180 lines total.

## Test plan
- A=12, D=2, valid rises → P=2, E=2, Q=3, err=0. done pulses 14 edges after accept; busy high throughout.
- A=31, D=31 → P=31, E=1, Q=1, done at accept+1.
- A=128, D=2 → E=7, Q=1. Also A=255, D=3 → E=1, Q=85.
- A=1, D=1 → P=1, E=0, Q=1, err=0. Also A=10, D=0 → err=1, E=0, Q=10.
- After done, hold valid=1 for 20 cycles → no second accept, busy stays 0. Drop valid, then raise it with A=9, D=3 → E=2, Q=1.
- Assert Rst during DIV with A=200, D=2 → all outputs 0 asynchronously. After release, no done appears until a new valid edge.
